// File: rtl/awb_gain_apply.sv
// awb_gain_apply: per-channel white-balance gain stage for a 24-bit RGB stream.
// New gains wait in a pending buffer and are swapped in on an accepted
// start-of-frame pixel, so a frame is never processed with mixed gains.
// Two-stage valid/ready pipeline: stage 1 multiplies, stage 2 rounds half-up
// and saturates. Also reports the clipped-pixel count of the last full frame.
module awb_gain_apply #(
  parameter int GAIN_W    = 12,
  parameter int GAIN_FRAC = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_enable_i,
  input  logic [GAIN_W-1:0] gain_r_i,
  input  logic [GAIN_W-1:0] gain_g_i,
  input  logic [GAIN_W-1:0] gain_b_i,
  input  logic              gain_update_i,
  input  logic [23:0]       rgb_data_i,
  input  logic              rgb_sof_i,
  input  logic              rgb_valid_i,
  output logic              rgb_ready_o,
  output logic [23:0]       pix_data_o,
  output logic              pix_sof_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              gain_pending_o,
  output logic [CNT_W-1:0]  clip_count_o
);

  localparam int PROD_W = GAIN_W + 8;
  localparam int RND_W  = PROD_W + 1;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);
  localparam logic [RND_W-1:0]  HALF  = RND_W'(1 << (GAIN_FRAC - 1));

  // Channel index 2 = R, 1 = G, 0 = B, matching the pixel packing.
  logic [2:0][GAIN_W-1:0] act_gain;
  logic [2:0][GAIN_W-1:0] pend_gain;
  logic [2:0][GAIN_W-1:0] gain_new;
  logic [2:0][GAIN_W-1:0] gain_sel;
  logic                   pend_flag;

  logic                   en;
  logic                   accept;
  logic                   take_pend;

  logic                   s1_valid;
  logic                   s1_sof;
  logic [2:0][PROD_W-1:0] s1_prod;

  logic [2:0][RND_W-1:0]  rnd;
  logic [2:0][7:0]        s2_pix;
  logic [2:0]             s2_sat;

  logic                   pix_clip;
  logic                   out_fire;
  logic [CNT_W-1:0]       running;

  // The whole pipeline moves together whenever the output slot is free or drains.
  assign en             = !pix_valid_o || pix_ready_i;
  assign rgb_ready_o    = en;
  assign accept         = rgb_valid_i && en;
  assign take_pend      = accept && rgb_sof_i && pend_flag;
  assign out_fire       = pix_valid_o && pix_ready_i;
  assign gain_new       = {gain_r_i, gain_g_i, gain_b_i};
  assign gain_pending_o = pend_flag;

  // Gain used by the pixel being accepted: the sof pixel that swaps already uses the pending set.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gain_sel = act_gain;
    if (take_pend)     gain_sel = pend_gain;
    if (!cfg_enable_i) gain_sel = {3{UNITY}};
  end

  // Pending/active gain double buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_gain  <= {3{UNITY}};
      pend_gain <= {3{UNITY}};
      pend_flag <= 1'b0;
    end else begin
      if (take_pend) begin
        act_gain  <= pend_gain;
        pend_flag <= 1'b0;
      end
      // NOTE: non-blocking assignments; the later one wins, so an update landing on the swap
      // cycle keeps the new values pending while the swap still copies the old pending set.
      if (gain_update_i) begin
        pend_gain <= gain_new;
        pend_flag <= 1'b1;
      end
    end
  end

  // Stage 1: per-channel product on accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= rgb_valid_i;
      if (rgb_valid_i) begin
        s1_sof <= rgb_sof_i;
        for (int c = 0; c < 3; c++) begin
          s1_prod[c] <= PROD_W'(rgb_data_i[8*c +: 8]) * PROD_W'(gain_sel[c]);
        end
      end
    end
  end

  // Half-up rounding to integer, then saturation to 8 bits.
  always_comb begin
    rnd    = '0;
    s2_pix = '0;
    s2_sat = '0;
    for (int c = 0; c < 3; c++) begin
      rnd[c]    = (RND_W'(s1_prod[c]) + HALF) >> GAIN_FRAC;
      s2_sat[c] = |rnd[c][RND_W-1:8];
      s2_pix[c] = s2_sat[c] ? 8'hFF : rnd[c][7:0];
    end
  end

  // Stage 2: output register with the pixel's clip flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_valid_o <= 1'b0;
      pix_data_o  <= '0;
      pix_sof_o   <= 1'b0;
      pix_clip    <= 1'b0;
    end else if (en) begin
      pix_valid_o <= s1_valid;
      if (s1_valid) begin
        pix_data_o <= s2_pix;
        pix_sof_o  <= s1_sof;
        pix_clip   <= |s2_sat;
      end
    end
  end

  // Per-frame clip statistics, counted at the output handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      running      <= '0;
      clip_count_o <= '0;
    end else if (out_fire) begin
      if (pix_sof_o) begin
        clip_count_o <= running;
        running      <= CNT_W'(pix_clip);
      end else if (pix_clip && (running != '1)) begin
        running <= running + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_apply.sv
// Self-checking bench for awb_gain_apply: directed scenarios with fixed
// expected pixels plus a randomized run against a transaction-level model.
module tb_awb_gain_apply;

  localparam int GAIN_W    = 12;
  localparam int GAIN_FRAC = 8;
  localparam int CNT_W     = 16;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              cfg_enable_i;
  logic [GAIN_W-1:0] gain_r_i, gain_g_i, gain_b_i;
  logic              gain_update_i;
  logic [23:0]       rgb_data_i;
  logic              rgb_sof_i;
  logic              rgb_valid_i;
  logic              rgb_ready_o;
  logic [23:0]       pix_data_o;
  logic              pix_sof_o;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic              gain_pending_o;
  logic [CNT_W-1:0]  clip_count_o;

  awb_gain_apply #(.GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_enable_i(cfg_enable_i),
    .gain_r_i(gain_r_i), .gain_g_i(gain_g_i), .gain_b_i(gain_b_i),
    .gain_update_i(gain_update_i), .rgb_data_i(rgb_data_i), .rgb_sof_i(rgb_sof_i),
    .rgb_valid_i(rgb_valid_i), .rgb_ready_o(rgb_ready_o), .pix_data_o(pix_data_o),
    .pix_sof_o(pix_sof_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .gain_pending_o(gain_pending_o), .clip_count_o(clip_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk_i) cyc++;

  // Expected and observed output streams: {data, sof}.
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  // Model's own per-pixel {sof, clipped}, consumed as pixels leave the DUT.
  logic [1:0]  stat_q[$];

  // Reference model state.
  int          m_act[3];
  int          m_pend[3];
  int          m_g[3];
  bit          m_flag;
  bit          m_use;
  bit          m_clip;
  int          m_v;
  int          m_running;
  int          m_clip_count;
  logic [23:0] m_px;
  logic [1:0]  m_st;

  // Reference model: gains are a pending set that becomes active on an accepted
  // sof; each channel is round(ch * gain / 256) capped at 255.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < 3; c++) begin
        m_act[c]  = 256;
        m_pend[c] = 256;
      end
      m_flag       = 1'b0;
      m_running    = 0;
      m_clip_count = 0;
      exp_q.delete();
      obs_q.delete();
      stat_q.delete();
    end else begin
      if (pix_valid_o && pix_ready_i) begin
        obs_q.push_back({pix_data_o, pix_sof_o});
        m_st = (stat_q.size() > 0) ? stat_q.pop_front() : 2'b00;
        if (m_st[1]) begin
          m_clip_count = m_running;
          m_running    = int'(m_st[0]);
        end else if (m_st[0] && m_running < (1 << CNT_W) - 1) begin
          m_running++;
        end
      end
      if (rgb_valid_i && rgb_ready_o) begin
        m_use  = rgb_sof_i && m_flag;
        m_clip = 1'b0;
        for (int c = 0; c < 3; c++) m_g[c] = !cfg_enable_i ? 256 : (m_use ? m_pend[c] : m_act[c]);
        if (m_use) begin
          for (int c = 0; c < 3; c++) m_act[c] = m_pend[c];
          m_flag = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
          m_v = (int'(rgb_data_i[8*c +: 8]) * m_g[c] + 128) / 256;
          if (m_v > 255) begin
            m_v    = 255;
            m_clip = 1'b1;
          end
          m_px[8*c +: 8] = 8'(m_v);
        end
        exp_q.push_back({m_px, rgb_sof_i});
        stat_q.push_back({rgb_sof_i, m_clip});
      end
      if (gain_update_i) begin
        m_pend[2] = int'(gain_r_i);
        m_pend[1] = int'(gain_g_i);
        m_pend[0] = int'(gain_b_i);
        m_flag    = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(negedge clk_i);
    if (rand_ready) pix_ready_i = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic set_update(input logic [GAIN_W-1:0] r, input logic [GAIN_W-1:0] g,
                            input logic [GAIN_W-1:0] b);
    gain_r_i      = r;
    gain_g_i      = g;
    gain_b_i      = b;
    gain_update_i = 1'b1;
  endtask

  task automatic pulse_update(input logic [GAIN_W-1:0] r, input logic [GAIN_W-1:0] g,
                              input logic [GAIN_W-1:0] b);
    set_update(r, g, b);
    step();
    gain_update_i = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input bit sof, input bit en = 1'b1);
    int n = 0;
    rgb_data_i   = d;
    rgb_sof_i    = sof;
    cfg_enable_i = en;
    rgb_valid_i  = 1'b1;
    while (!rgb_ready_o && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: rgb_ready_o stayed %b for %0d cycles, required 1", rgb_ready_o, n);
    end
    step();
    rgb_valid_i   = 1'b0;
    rgb_sof_i     = 1'b0;
    gain_update_i = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    rgb_valid_i   = 1'b0;
    rgb_sof_i     = 1'b0;
    gain_update_i = 1'b0;
    rand_ready    = 1'b0;
    pix_ready_i   = 1'b1;
    while ((obs_q.size() < exp_q.size() || pix_valid_o) && n < 64) begin
      step();
      n++;
    end
    timed_out = (n >= 64);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n_i       = 1'b0;
    cfg_enable_i  = 1'b1;
    gain_r_i      = '0;
    gain_g_i      = '0;
    gain_b_i      = '0;
    gain_update_i = 1'b0;
    rgb_data_i    = '0;
    rgb_sof_i     = 1'b0;
    rgb_valid_i   = 1'b0;
    pix_ready_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", pix_valid_o); end
    checks++; if (pix_data_o !== 24'h0) begin failures++; $display("FAIL reset_data: got %h expected 000000", pix_data_o); end
    checks++; if (pix_sof_o !== 1'b0) begin failures++; $display("FAIL reset_sof: got %b expected 0", pix_sof_o); end
    checks++; if (rgb_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rgb_ready_o); end
    checks++; if (gain_pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", gain_pending_o); end
    checks++; if (clip_count_o !== '0) begin failures++; $display("FAIL reset_clip_count: got %0d expected 0", clip_count_o); end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_unity();
    logic [23:0] d[8];
    int          t0;
    bit          to;
    pix_ready_i = 1'b1;
    send(24'h804020, 1'b1);
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("FAIL unity_latency1: pix_valid_o=%b expected 0", pix_valid_o); end
    step();
    checks++; if (pix_valid_o !== 1'b1) begin failures++; $display("FAIL unity_latency2: pix_valid_o=%b expected 1", pix_valid_o); end
    checks++; if (pix_data_o !== 24'h804020) begin failures++; $display("FAIL unity_data: got %h expected 804020", pix_data_o); end
    checks++; if (rgb_ready_o !== 1'b1) begin failures++; $display("FAIL unity_ready: got %b expected 1", rgb_ready_o); end
    // back-to-back: one pixel per cycle
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d[i] = 24'($urandom);
      send(d[i], 1'b0);
    end
    checks++; if (cyc - t0 !== 8) begin failures++; $display("FAIL back_to_back_cycles: got %0d expected 8", cyc - t0); end
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL unity_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 9) begin failures++; $display("FAIL unity_count: got %0d expected 9", obs_q.size()); end
    if (obs_q.size() == 9) begin
      checks++; if (obs_q[0] !== {24'h804020, 1'b1}) begin failures++; $display("FAIL unity_px0: got %h expected %h", obs_q[0], {24'h804020, 1'b1}); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (obs_q[i+1] !== {d[i], 1'b0}) begin failures++; $display("FAIL unity_b2b px %0d: got %h expected %h", i, obs_q[i+1], {d[i], 1'b0}); end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_gain_clip();
    logic [23:0] want[3];
    bit          to;
    want = '{24'hC04020, 24'hFF1010, 24'h181010};
    pulse_update(12'h180, 12'h100, 12'h100);
    checks++; if (gain_pending_o !== 1'b1) begin failures++; $display("FAIL clip_pending_set: got %b expected 1", gain_pending_o); end
    send(24'h804020, 1'b1);
    checks++; if (gain_pending_o !== 1'b0) begin failures++; $display("FAIL clip_pending_clr: got %b expected 0", gain_pending_o); end
    send(24'hFF1010, 1'b0);
    send(24'h101010, 1'b1);
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL clip_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL clip_count_px: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i][24:1] !== want[i]) begin failures++; $display("FAIL clip_px %0d: got %h expected %h", i, obs_q[i][24:1], want[i]); end
    end
    checks++; if (clip_count_o !== 16'd1) begin failures++; $display("FAIL clip_count_frame: got %0d expected 1", clip_count_o); end
    checks++; if (clip_count_o !== CNT_W'(m_clip_count)) begin failures++; $display("FAIL clip_count_model: got %0d expected %0d", clip_count_o, m_clip_count); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rounding();
    logic [23:0] want[5];
    bit          to;
    want = '{24'h040000, 24'h020000, 24'hBF00FF, 24'hFFFFFF, 24'h000000};
    pulse_update(12'h0C0, 12'h000, 12'h100);
    send(24'h050000, 1'b1);
    send(24'h020000, 1'b0);
    send(24'hFFFFFF, 1'b0);
    send(24'hFFFFFF, 1'b0, 1'b0);
    send(24'h000000, 1'b1);
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL round_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 5) begin failures++; $display("FAIL round_count: got %0d expected 5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i][24:1] !== want[i]) begin failures++; $display("FAIL round_px %0d: got %h expected %h", i, obs_q[i][24:1], want[i]); end
    end
    checks++; if (clip_count_o !== 16'd0) begin failures++; $display("FAIL round_clip_count: got %0d expected 0", clip_count_o); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_boundary();
    bit to;
    pulse_update(12'h100, 12'h100, 12'h100);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) set_update(12'h080, 12'h080, 12'h080);
      send(24'h808080, i == 0);
      if (i == 10) begin
        checks++; if (gain_pending_o !== 1'b1) begin failures++; $display("FAIL frame_pending_mid: got %b expected 1", gain_pending_o); end
      end
    end
    set_update(12'h200, 12'h200, 12'h200);
    send(24'h808080, 1'b1);
    checks++; if (gain_pending_o !== 1'b1) begin failures++; $display("FAIL frame_pending_same_cycle: got %b expected 1", gain_pending_o); end
    send(24'h808080, 1'b0);
    send(24'h808080, 1'b1);
    checks++; if (gain_pending_o !== 1'b0) begin failures++; $display("FAIL frame_pending_clr: got %b expected 0", gain_pending_o); end
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL frame_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 23 || exp_q.size() !== 23) begin failures++; $display("FAIL frame_count: got %0d model %0d expected 23", obs_q.size(), exp_q.size()); end
    if (obs_q.size() == 23) begin
      checks++; if (obs_q[19][24:1] !== 24'h808080) begin failures++; $display("FAIL frame_old_gain: got %h expected 808080", obs_q[19][24:1]); end
      checks++; if (obs_q[20] !== {24'h404040, 1'b1}) begin failures++; $display("FAIL frame_new_sof: got %h expected %h", obs_q[20], {24'h404040, 1'b1}); end
      checks++; if (obs_q[21][24:1] !== 24'h404040) begin failures++; $display("FAIL frame_after_sof: got %h expected 404040", obs_q[21][24:1]); end
      checks++; if (obs_q[22][24:1] !== 24'hFFFFFF) begin failures++; $display("FAIL frame_late_update: got %h expected FFFFFF", obs_q[22][24:1]); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL frame_model px %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stall();
    bit to;
    pulse_update(12'h100, 12'h100, 12'h100);
    pix_ready_i = 1'b0;
    send(24'h123456, 1'b1);
    send(24'h654321, 1'b0);
    rgb_data_i   = 24'hABCDEF;
    rgb_sof_i    = 1'b0;
    cfg_enable_i = 1'b1;
    rgb_valid_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rgb_ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready cyc %0d: got %b expected 0", i, rgb_ready_o); end
      checks++; if (pix_valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid cyc %0d: got %b expected 1", i, pix_valid_o); end
      checks++; if (pix_data_o !== 24'h123456) begin failures++; $display("FAIL stall_data cyc %0d: got %h expected 123456", i, pix_data_o); end
      checks++; if (pix_sof_o !== 1'b1) begin failures++; $display("FAIL stall_sof cyc %0d: got %b expected 1", i, pix_sof_o); end
    end
    pix_ready_i = 1'b1;
    step();
    rgb_valid_i = 1'b0;
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL stall_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL stall_count: got %0d expected 3 (no drop, no duplicate)", obs_q.size()); end
    if (obs_q.size() == 3) begin
      checks++; if (obs_q[0] !== {24'h123456, 1'b1}) begin failures++; $display("FAIL stall_px0: got %h expected %h", obs_q[0], {24'h123456, 1'b1}); end
      checks++; if (obs_q[1] !== {24'h654321, 1'b0}) begin failures++; $display("FAIL stall_px1: got %h expected %h", obs_q[1], {24'h654321, 1'b0}); end
      checks++; if (obs_q[2] !== {24'hABCDEF, 1'b0}) begin failures++; $display("FAIL stall_px2: got %h expected %h", obs_q[2], {24'hABCDEF, 1'b0}); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int  npx = 0;
    int  len;
    bit  to;
    rand_ready = 1'b1;
    while (npx < 1000) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len && npx < 1000; i++) begin
        if ($urandom_range(0, 19) == 0) set_update(12'($urandom), 12'($urandom), 12'($urandom));
        if ($urandom_range(0, 4) == 0) step();
        send(24'($urandom), i == 0, $urandom_range(0, 9) != 0);
        npx++;
      end
    end
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL random_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 1000 || exp_q.size() !== 1000) begin failures++; $display("FAIL random_count: got %0d model %0d expected 1000", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random px %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (clip_count_o !== CNT_W'(m_clip_count)) begin failures++; $display("FAIL random_clip_count: got %0d expected %0d", clip_count_o, m_clip_count); end
    checks++; if (gain_pending_o !== m_flag) begin failures++; $display("FAIL random_pending: got %b expected %b", gain_pending_o, m_flag); end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    bit to;
    rand_ready  = 1'b0;
    pix_ready_i = 1'b1;
    pulse_update(12'h200, 12'h200, 12'h200);
    send(24'h101010, 1'b1);
    send(24'hFFFFFF, 1'b0);
    send(24'h101010, 1'b1);
    drain(to);
    pulse_update(12'h080, 12'h080, 12'h080);
    send(24'h111111, 1'b0);
    send(24'h222222, 1'b0);
    checks++; if (clip_count_o !== 16'd1) begin failures++; $display("FAIL rst_pre_clip_count: got %0d expected 1", clip_count_o); end
    checks++; if (pix_valid_o !== 1'b1) begin failures++; $display("FAIL rst_pre_valid: got %b expected 1", pix_valid_o); end
    checks++; if (gain_pending_o !== 1'b1) begin failures++; $display("FAIL rst_pre_pending: got %b expected 1", gain_pending_o); end
    rst_n_i = 1'b0;
    #1;
    checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b expected 0", pix_valid_o); end
    checks++; if (pix_data_o !== 24'h0) begin failures++; $display("FAIL rst_mid_data: got %h expected 000000", pix_data_o); end
    checks++; if (rgb_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", rgb_ready_o); end
    checks++; if (gain_pending_o !== 1'b0) begin failures++; $display("FAIL rst_mid_pending: got %b expected 0", gain_pending_o); end
    checks++; if (clip_count_o !== '0) begin failures++; $display("FAIL rst_mid_clip_count: got %0d expected 0", clip_count_o); end
    repeat (2) step();
    rst_n_i = 1'b1;
    step();
    send(24'h804020, 1'b1);
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL rst_post_drain: outputs %0d expected %0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL rst_post_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      checks++; if (obs_q[0] !== {24'h804020, 1'b1}) begin failures++; $display("FAIL rst_post_unity: got %h expected %h", obs_q[0], {24'h804020, 1'b1}); end
    end
    checks++; if (clip_count_o !== '0) begin failures++; $display("FAIL rst_post_clip_count: got %0d expected 0", clip_count_o); end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_unity();
    test_gain_clip();
    test_rounding();
    test_frame_boundary();
    test_stall();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
